// File: rtl/triloc_range_gen_if.sv
// Port bundle for triloc_range_gen: coordinate inputs, start/busy/done handshake,
// range results and an FSM state tap.
interface triloc_range_gen_if #(
    parameter int N = 8
);
    // start is sampled only while idle; busy covers the accept edge up to, not
    // including, the done edge; done pulses one cycle with rA..rC updated.
    logic                start;
    logic signed [N-1:0] xT, yT, xA, yA, xB, yB, xC, yC;
    logic                busy;
    logic                done;
    logic        [N:0]   rA, rB, rC;
    logic        [1:0]   fsm_state;

    modport master (
        output start, xT, yT, xA, yA, xB, yB, xC, yC,
        input  busy, done, rA, rB, rC, fsm_state
    );

    modport slave (
        input  start, xT, yT, xA, yA, xB, yB, xC, yC,
        output busy, done, rA, rB, rC, fsm_state
    );
endinterface

// File: rtl/triloc_range_gen.sv
// Forward range model for TriLoc: one shared squared-distance stage and one
// restoring square root, time-multiplexed over anchors A, B, C.
module triloc_range_gen #(
    parameter int N = 8
) (
    input logic                clk,
    input logic                rst_n,
    triloc_range_gen_if.slave  bus
);
    localparam int CW = $clog2(N + 1);
    localparam int RW = 2 * N + 2;

    typedef enum logic [1:0] {IDLE = 2'd0, SQ = 2'd1, ROOT = 2'd2} state_t;

    state_t state, state_nx;
    logic load, sq_en, root_en, last;

    logic signed [N-1:0] xt, yt, xa, ya, xb, yb, xc, yc;
    logic        [1:0]   k;
    logic        [CW-1:0] cnt;
    logic        [RW-1:0] rad;
    logic        [N:0]   root;
    logic        [N+2:0] rem;
    logic        [N:0]   res_a, res_b;
    logic        [N:0]   ra, rb, rc;
    logic                busy, done;

    logic signed [N-1:0] xk, yk;
    logic        [N:0]   dx, dy, adx, ady;
    logic      [2*N-1:0] mag_x, mag_y, sq_x, sq_y;
    logic        [RW-1:0] rad_nx;
    logic        [N+4:0] rem_sh, trial;
    logic                ge;
    logic        [N:0]   root_nx;
    logic        [N+2:0] rem_nx;

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        sq_en    = 1'b0;
        root_en  = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = SQ;
                end
            end
            SQ: begin
                sq_en    = 1'b1;
                state_nx = ROOT;
            end
            ROOT: begin
                root_en = 1'b1;
                if (cnt == CW'(N)) begin
                    last     = 1'b1;
                    state_nx = (k == 2'd2) ? IDLE : SQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Squared distance to the current anchor; differences at N+1 bits cannot overflow.
    always_comb begin
        case (k)
            2'd0:    begin xk = xa; yk = ya; end
            2'd1:    begin xk = xb; yk = yb; end
            default: begin xk = xc; yk = yc; end
        endcase
        dx     = {xt[N-1], xt} - {xk[N-1], xk};
        dy     = {yt[N-1], yt} - {yk[N-1], yk};
        adx    = dx[N] ? (~dx + 1'b1) : dx;
        ady    = dy[N] ? (~dy + 1'b1) : dy;
        mag_x  = (2*N)'(adx);
        mag_y  = (2*N)'(ady);
        sq_x   = mag_x * mag_x;
        sq_y   = mag_y * mag_y;
        rad_nx = RW'({1'b0, sq_x} + {1'b0, sq_y});
    end

    // One restoring root digit: bring down two radicand bits, try subtracting 4q+1.
    always_comb begin
        rem_sh  = (N+5)'({rem, rad[RW-1:RW-2]});
        trial   = (N+5)'({root, 2'b01});
        ge      = (rem_sh >= trial);
        root_nx = {root[N-1:0], ge};
        rem_nx  = ge ? (N+3)'(rem_sh - trial) : (N+3)'(rem_sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xt <= '0; yt <= '0; xa <= '0; ya <= '0;
            xb <= '0; yb <= '0; xc <= '0; yc <= '0;
            k     <= 2'd0;
            cnt   <= '0;
            rad   <= '0;
            root  <= '0;
            rem   <= '0;
            res_a <= '0;
            res_b <= '0;
            ra    <= '0;
            rb    <= '0;
            rc    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                xt <= bus.xT; yt <= bus.yT;
                xa <= bus.xA; ya <= bus.yA;
                xb <= bus.xB; yb <= bus.yB;
                xc <= bus.xC; yc <= bus.yC;
                k    <= 2'd0;
                busy <= 1'b1;
            end
            if (sq_en) begin
                rad  <= rad_nx;
                root <= '0;
                rem  <= '0;
                cnt  <= '0;
            end
            if (root_en) begin
                rad  <= {rad[RW-3:0], 2'b00};
                root <= root_nx;
                rem  <= rem_nx;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    case (k)
                        2'd0: res_a <= root_nx;
                        2'd1: res_b <= root_nx;
                        default: begin
                            ra   <= res_a;
                            rb   <= res_b;
                            rc   <= root_nx;
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    endcase
                    if (k != 2'd2) k <= k + 2'd1;
                end
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rA        = ra;
    assign bus.rB        = rb;
    assign bus.rC        = rc;
    assign bus.fsm_state = state;
endmodule
